ecc_encode_pipe: RTL and testbench

Pipelined, multi-mode Hamming SECDED encoder that turns a data word into a codeword for 8-, 16- or 32-bit codewords, selected per word. It is the parametrised successor of the fixed 32-bit parity generator. It sits between the register/bus front end and the memory/channel model. It adds valid/ready flow control, a two-stage pipeline, per-word mode, reserved-mode flagging and a saturating encoded-word counter.

---
 rtl/ecc_pkg.sv | 60 ++++++
 rtl/hamming_parity_gen.sv | 23 ++
 rtl/ecc_encode_pipe.sv | 91 +++++++++
 tb/tb_ecc_encode_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and constant helpers for the multi-mode SECDED encoder.
package ecc_pkg;

  localparam int unsigned MAX_K  = 26;
  localparam int unsigned MAX_R  = 5;
  localparam int unsigned MAX_CW = 32;

  typedef enum logic [1:0] {
    MODE_8   = 2'b00,
    MODE_16  = 2'b01,
    MODE_32  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Stage-1 payload: masked data plus the parities computed on the way in
  typedef struct packed {
    mode_e            mode;
    logic [MAX_K-1:0] data;
    logic [MAX_R-1:0] p;
    logic             ovr;
  } s1_t;

  function automatic int unsigned data_bits(mode_e m);
    case (m)
      MODE_8:  return 4;
      MODE_16: return 11;
      MODE_32: return 26;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned ham_bits(mode_e m);
    case (m)
      MODE_8:  return 3;
      MODE_16: return 4;
      MODE_32: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned cw_bits(mode_e m);
    return data_bits(m) + ham_bits(m) + 1;
  endfunction

  // Hamming position of data bit j: j-th non-power-of-two position from 3
  function automatic int unsigned ham_pos(int unsigned j);
    int unsigned n;
    int unsigned res;
    n   = 0;
    res = 0;
    for (int unsigned q = 3; q < 64; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (n == j) res = q;
        n++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming parity and overall-parity generator for K data bits.
module hamming_parity_gen
  import ecc_pkg::*;
#(
  parameter int unsigned K = 4,
  parameter int unsigned R = 3
) (
  input  logic [K-1:0] data,
  output logic [R-1:0] p,
  output logic         ovr
);

  always_comb begin
    p = '0;
    for (int unsigned j = 0; j < K; j++) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (((ham_pos(j) >> i) & 1) != 0) p[i] = p[i] ^ data[j];
      end
    end
    ovr = ^{data, p};
  end

endmodule

// File: rtl/ecc_encode_pipe.sv
// Two-stage valid/ready SECDED encoder producing 8/16/32-bit codewords per word.
module ecc_encode_pipe
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [1:0]            MODE,
  input  logic [MAX_K-1:0]      DATA_IN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] CodeWord,
  output logic                  MODE_ERR,
  input  logic                  CLR_CNT,
  output logic [CNT_WIDTH-1:0]  ENC_CNT
);

  mode_e              in_mode;
  logic [MAX_K-1:0]   in_data;
  logic [2:0]         p8;
  logic [3:0]         p16;
  logic [4:0]         p32;
  logic               o8, o16, o32;
  s1_t                s1_d, s1_q;
  logic               s1_valid;
  logic               s2_ready, in_fire, out_fire;
  logic               s2_err;
  logic [MAX_CW-1:0]  cw_full;

  assign in_mode  = mode_e'(MODE);
  assign in_data  = DATA_IN & MAX_K'((27'(1) << data_bits(in_mode)) - 27'(1));

  assign s2_ready = !OUT_VALID || OUT_READY;
  assign IN_READY = !s1_valid || s2_ready;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = OUT_VALID && OUT_READY;

  hamming_parity_gen #(.K(4),  .R(3)) u_gen8  (.data(in_data[3:0]),  .p(p8),  .ovr(o8));
  hamming_parity_gen #(.K(11), .R(4)) u_gen16 (.data(in_data[10:0]), .p(p16), .ovr(o16));
  hamming_parity_gen #(.K(26), .R(5)) u_gen32 (.data(in_data[25:0]), .p(p32), .ovr(o32));

  // Stage-1 payload: pick the generator matching the incoming mode
  always_comb begin
    s1_d      = '0;
    s1_d.mode = in_mode;
    s1_d.data = in_data;
    case (in_mode)
      MODE_8:  begin s1_d.p = MAX_R'(p8);  s1_d.ovr = o8;  end
      MODE_16: begin s1_d.p = MAX_R'(p16); s1_d.ovr = o16; end
      MODE_32: begin s1_d.p = p32;         s1_d.ovr = o32; end
      default: begin s1_d.p = '0;          s1_d.ovr = 1'b0; end
    endcase
  end

  // Stage-2 assembly: {data, overall, hamming}; modes wider than the port are rejected
  always_comb begin
    s2_err  = (s1_q.mode == MODE_RSV) || (cw_bits(s1_q.mode) > DATA_WIDTH);
    cw_full = (MAX_CW'(s1_q.data) << (ham_bits(s1_q.mode) + 1))
            | (MAX_CW'(s1_q.ovr) << ham_bits(s1_q.mode))
            | MAX_CW'(s1_q.p);
    if (s2_err) cw_full = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      OUT_VALID <= 1'b0;
      CodeWord  <= '0;
      MODE_ERR  <= 1'b0;
      ENC_CNT   <= '0;
    end else begin
      if (IN_READY) s1_valid <= IN_VALID;
      if (in_fire)  s1_q     <= s1_d;
      if (s2_ready) begin
        OUT_VALID <= s1_valid;
        if (s1_valid) begin
          CodeWord <= DATA_WIDTH'(cw_full);
          MODE_ERR <= s2_err;
        end
      end
      if (CLR_CNT)                      ENC_CNT <= '0;
      else if (out_fire && ENC_CNT != '1) ENC_CNT <= ENC_CNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecc_encode_pipe.sv
// Directed + random bench for ecc_encode_pipe with a positional-syndrome reference model.
module tb_ecc_encode_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clr_cnt;
  logic [1:0]  mode;
  logic [25:0] data_in;
  logic        in_ready, out_valid, mode_err;
  logic [31:0] code_word;
  logic [15:0] enc_cnt;
  logic        in_ready4, out_valid4, mode_err4;
  logic [15:0] code_word4;
  logic [3:0]  enc_cnt4;

  logic [32:0] q[$];
  logic [32:0] q4[$];
  int unsigned cnt, cnt4;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  ecc_encode_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .MODE(mode), .DATA_IN(data_in), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .CodeWord(code_word), .MODE_ERR(mode_err), .CLR_CNT(clr_cnt), .ENC_CNT(enc_cnt));

  // Narrow instance: 16-bit port makes 32-bit mode unsupported, 4-bit counter saturates early
  ecc_encode_pipe #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .IN_VALID(in_valid), .IN_READY(in_ready4),
    .MODE(mode), .DATA_IN(data_in), .OUT_VALID(out_valid4), .OUT_READY(out_ready),
    .CodeWord(code_word4), .MODE_ERR(mode_err4), .CLR_CNT(clr_cnt), .ENC_CNT(enc_cnt4));

  // Reference: hamming bits = XOR of positions of set data bits, overall = parity of everything
  function automatic logic [32:0] model(input int unsigned m, input logic [25:0] d,
                                        input int unsigned dw);
    int unsigned k, r, pos, syn;
    logic [31:0] dm;
    bit ovr;
    case (m)
      0: begin k = 4;  r = 3; end
      1: begin k = 11; r = 4; end
      2: begin k = 26; r = 5; end
      default: begin k = 0; r = 0; end
    endcase
    if (m == 3 || k + r + 1 > dw) return {1'b1, 32'h0};
    syn = 0;
    pos = 3;
    ovr = 1'b0;
    for (int j = 0; j < int'(k); j++) begin
      while ($countones(pos) == 1) pos++;
      if (d[j]) begin
        syn = syn ^ pos;
        ovr = ~ovr;
      end
      pos++;
    end
    if ($countones(syn) % 2 == 1) ovr = ~ovr;
    dm = 32'(d) & ((32'd1 << k) - 32'd1);
    return {1'b0, (dm << (r + 1)) | (32'(ovr) << r) | syn};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, score handshakes about to happen, then advance one clock
  task automatic step();
    logic [32:0] e;
    #1;
    if (rst) begin
      q.delete();
      q4.delete();
      cnt  = 0;
      cnt4 = 0;
    end else begin
      chk("enc_cnt",  64'(enc_cnt),  64'(cnt  > 65535 ? 65535 : cnt));
      chk("enc_cnt4", 64'(enc_cnt4), 64'(cnt4 > 15 ? 15 : cnt4));
      if (out_valid && out_ready) begin
        chk("sb_has_word", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("codeword", 64'(code_word), 64'(e[31:0]));
          chk("mode_err", 64'(mode_err),  64'(e[32]));
        end
      end
      if (out_valid4 && out_ready) begin
        chk("sb4_has_word", 64'(q4.size() > 0), 64'(1));
        if (q4.size() > 0) begin
          e = q4.pop_front();
          chk("codeword4", 64'(code_word4), 64'(e[15:0]));
          chk("mode_err4", 64'(mode_err4),  64'(e[32]));
        end
      end
      if (clr_cnt) cnt = 0;
      else if (out_valid && out_ready) cnt++;
      if (clr_cnt) cnt4 = 0;
      else if (out_valid4 && out_ready) cnt4++;
      if (in_valid && in_ready)  q.push_back(model(32'(mode), data_in, 32));
      if (in_valid && in_ready4) q4.push_back(model(32'(mode), data_in, 16));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single(input logic [1:0] m, input logic [25:0] d,
                        input logic [31:0] exp_cw, input logic exp_err);
    in_valid = 1'b1;
    mode     = m;
    data_in  = d;
    step();
    in_valid = 1'b0;
    chk("lat1_out_valid", 64'(out_valid), 64'(0));
    step();
    chk("lat2_out_valid", 64'(out_valid), 64'(1));
    chk("single_cw",      64'(code_word), 64'(exp_cw));
    chk("single_err",     64'(mode_err),  64'(exp_err));
    step();
  endtask

  initial begin
    logic [32:0] e0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    mode = 2'b00; data_in = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_codeword",  64'(code_word), 64'(0));
    chk("rst_mode_err",  64'(mode_err),  64'(0));
    chk("rst_enc_cnt",   64'(enc_cnt),   64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));

    single(2'b10, 26'h1,       32'h0000_0063, 1'b0);
    single(2'b01, 26'h1,       32'h0000_0033, 1'b0);
    single(2'b00, 26'h1,       32'h0000_001B, 1'b0);
    single(2'b00, 26'hF,       32'h0000_00FF, 1'b0);
    single(2'b00, 26'h3FFFFF1, 32'h0000_001B, 1'b0);
    single(2'b11, 26'($urandom), 32'h0,       1'b1);
    single(2'b10, 26'h1,       32'h0000_0063, 1'b0);

    // Back-to-back random stream, counter cleared first
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      mode     = 2'($urandom_range(0, 3));
      data_in  = 26'($urandom);
      chk("stream_in_ready", 64'(in_ready), 64'(1));
      if (i >= 2) chk("stream_out_valid", 64'(out_valid), 64'(1));
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_enc_cnt",  64'(enc_cnt),  64'(100));
    chk("stream_enc_cnt4", 64'(enc_cnt4), 64'(4'hF));
    chk("stream_drained",  64'(q.size()), 64'(0));

    // Backpressure: two words fill the pipe, then input must stall
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      if (i < 2) begin
        mode    = 2'($urandom_range(0, 2));
        data_in = 26'($urandom);
      end
      if (i >= 2) begin
        chk("bp_in_ready",  64'(in_ready),  64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        e0 = (q.size() > 0) ? q[0] : 33'h1_DEAD_BEEF;
        chk("bp_cw_stable", 64'(code_word), 64'(e0[31:0]));
      end
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("bp_no_loss",  64'(q.size()),  64'(0));
    chk("bp_no_loss4", 64'(q4.size()), 64'(0));

    // Clear coinciding with an output handshake wins
    in_valid = 1'b1;
    mode     = 2'b01;
    data_in  = 26'($urandom);
    step();
    in_valid = 1'b0;
    step();
    clr_cnt = 1'b1;
    chk("clr_hs_pending", 64'(out_valid), 64'(1));
    step();
    clr_cnt = 1'b0;
    chk("clr_hs_cnt",  64'(enc_cnt),  64'(0));
    chk("clr_hs_cnt4", 64'(enc_cnt4), 64'(0));

    // Reset mid-stream discards both stages
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      mode     = 2'($urandom_range(0, 2));
      data_in  = 26'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_codeword",  64'(code_word), 64'(0));
    chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
    chk("mid_rst_enc_cnt",   64'(enc_cnt),   64'(0));
    step();
    chk("mid_rst_s1_empty",  64'(out_valid), 64'(0));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
